// File: rtl/gpio_ctrl24_pkg.sv
// Shared register offsets, reset values and interrupt-type encoding for the
// APB GPIO controller.
package gpio_ctrl_pkg24;

    localparam logic [2:0] DOUT_OFF     = 3'd0;
    localparam logic [2:0] OE_N_OFF     = 3'd1;
    localparam logic [2:0] DIN_OFF      = 3'd2;
    localparam logic [2:0] INT_EN_OFF   = 3'd3;
    localparam logic [2:0] INT_TYPE_OFF = 3'd4;
    localparam logic [2:0] INT_POL_OFF  = 3'd5;
    localparam logic [2:0] INT_STAT_OFF = 3'd6;

    localparam logic [31:0] DOUT_RST     = 32'h0000_0000;
    localparam logic [31:0] OE_N_RST     = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_EN_RST   = 32'h0000_0000;
    localparam logic [31:0] INT_TYPE_RST = 32'h0000_0000;
    localparam logic [31:0] INT_POL_RST  = 32'h0000_0000;
    localparam logic [31:0] INT_STAT_RST = 32'h0000_0000;

    typedef enum logic {
        LEVEL = 1'b0,
        EDGE  = 1'b1
    } int_type_e;

endpackage

// File: rtl/gpio_ctrl24_in_sync.sv
// Three-flop input synchroniser; rise/fall compare the last two stages so the
// first stage never feeds logic directly.
module gpio_in_sync24 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pin_in,
    output logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    logic [WIDTH-1:0] s1, s2, s3;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= pin_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign din  = s2;
    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

endmodule

// File: rtl/gpio_ctrl24.sv
// APB GPIO controller: register file, pad drive, synchronised inputs and a
// masked level/edge interrupt.
module gpio_ctrl24
    import gpio_ctrl_pkg24::*;
#(
    parameter int GPIO_DATA_WIDTH = 16,
    parameter int ADDR_WIDTH      = 8
) (
    input  logic                       pclk24,
    input  logic                       p_reset24,
    input  logic                       psel24,
    input  logic                       penable24,
    input  logic                       pwrite24,
    input  logic [ADDR_WIDTH-1:0]      paddr24,
    input  logic [31:0]                pwdata24,
    output logic [31:0]                prdata24,
    output logic                       pready24,
    output logic                       pslverr24,
    output logic [GPIO_DATA_WIDTH-1:0] n_gpio_pin_oe24,
    output logic [GPIO_DATA_WIDTH-1:0] gpio_pin_out24,
    input  logic [GPIO_DATA_WIDTH-1:0] gpio_pin_in24,
    output logic                       gpio_int24
);

    localparam int W = GPIO_DATA_WIDTH;

    logic [W-1:0]  dout_q, oe_n_q, int_en_q, int_type_q, int_pol_q, int_stat_q;
    logic [W-1:0]  din, rise, fall, cond, w1c, wdata;
    logic [31:0]   prdata_q, rd_mux;
    logic [2:0]    idx;
    logic          unmapped, wr_en, rd_setup, gpio_int_q;
    logic          unused_bits;

    gpio_in_sync24 #(.WIDTH(W)) u_sync (
        .clk    (pclk24),
        .rst    (p_reset24),
        .pin_in (gpio_pin_in24),
        .din    (din),
        .rise   (rise),
        .fall   (fall)
    );

    // Anything at or past 0x1C is unmapped, including aliases above 0x1F.
    assign idx      = paddr24[4:2];
    assign unmapped = paddr24[ADDR_WIDTH-1:2] > (ADDR_WIDTH-2)'(INT_STAT_OFF);
    assign wr_en    = psel24 & penable24 & pwrite24 & ~unmapped;
    assign rd_setup = psel24 & ~penable24 & ~pwrite24;
    assign wdata    = pwdata24[W-1:0];
    assign w1c      = (wr_en && idx == INT_STAT_OFF) ? wdata : '0;

    for (genvar i = 0; i < W; i++) begin : g_evt
        assign cond[i] = (int_type_e'(int_type_q[i]) == EDGE)
                       ? (int_pol_q[i] ? rise[i] : fall[i])
                       : (din[i] == int_pol_q[i]);
    end

    always_comb begin
        rd_mux = '0;
        if (!unmapped) begin
            case (idx)
                DOUT_OFF:     rd_mux = 32'(dout_q);
                OE_N_OFF:     rd_mux = 32'(oe_n_q);
                DIN_OFF:      rd_mux = 32'(din);
                INT_EN_OFF:   rd_mux = 32'(int_en_q);
                INT_TYPE_OFF: rd_mux = 32'(int_type_q);
                INT_POL_OFF:  rd_mux = 32'(int_pol_q);
                INT_STAT_OFF: rd_mux = 32'(int_stat_q);
                default:      rd_mux = '0;
            endcase
        end
    end

    always_ff @(posedge pclk24) begin
        if (p_reset24) begin
            dout_q     <= DOUT_RST[W-1:0];
            oe_n_q     <= OE_N_RST[W-1:0];
            int_en_q   <= INT_EN_RST[W-1:0];
            int_type_q <= INT_TYPE_RST[W-1:0];
            int_pol_q  <= INT_POL_RST[W-1:0];
            int_stat_q <= INT_STAT_RST[W-1:0];
            gpio_int_q <= 1'b0;
            prdata_q   <= '0;
        end else begin
            if (wr_en) begin
                case (idx)
                    DOUT_OFF:     dout_q     <= wdata;
                    OE_N_OFF:     oe_n_q     <= wdata;
                    INT_EN_OFF:   int_en_q   <= wdata;
                    INT_TYPE_OFF: int_type_q <= wdata;
                    INT_POL_OFF:  int_pol_q  <= wdata;
                    default:      ;
                endcase
            end
            // A new event outranks a simultaneous write-1-to-clear.
            int_stat_q <= (int_stat_q & ~w1c) | (cond & int_en_q);
            gpio_int_q <= |(int_stat_q & int_en_q);
            if (rd_setup) prdata_q <= rd_mux;
        end
    end

    assign prdata24        = prdata_q;
    assign pready24        = 1'b1;
    assign pslverr24       = psel24 & penable24 & unmapped;
    assign gpio_pin_out24  = dout_q;
    assign n_gpio_pin_oe24 = oe_n_q;
    assign gpio_int24      = gpio_int_q;
    assign unused_bits     = &{1'b0, paddr24[1:0], pwdata24};

endmodule

// File: tb/tb_gpio_ctrl24.sv
// Bench for gpio_ctrl24: directed feature tasks plus a randomized run scored
// against a pin-history reference model.
module tb_gpio_ctrl24;

    logic        pclk24 = 1'b0;
    logic        p_reset24, psel24, penable24, pwrite24;
    logic [7:0]  paddr24;
    logic [31:0] pwdata24, prdata24;
    logic        pready24, pslverr24, gpio_int24;
    logic [15:0] n_gpio_pin_oe24, gpio_pin_out24, gpio_pin_in24;

    int checks = 0;
    int errors = 0;

    gpio_ctrl24 #(.GPIO_DATA_WIDTH(16), .ADDR_WIDTH(8)) dut (
        .pclk24          (pclk24),
        .p_reset24       (p_reset24),
        .psel24          (psel24),
        .penable24       (penable24),
        .pwrite24        (pwrite24),
        .paddr24         (paddr24),
        .pwdata24        (pwdata24),
        .prdata24        (prdata24),
        .pready24        (pready24),
        .pslverr24       (pslverr24),
        .n_gpio_pin_oe24 (n_gpio_pin_oe24),
        .gpio_pin_out24  (gpio_pin_out24),
        .gpio_pin_in24   (gpio_pin_in24),
        .gpio_int24      (gpio_int24)
    );

    always #5 pclk24 = ~pclk24;

    // Reference model: registers plus a history of pin samples, one per edge.
    // The value visible as DIN before edge n is the sample taken at edge n-2.
    logic [15:0] m_dout, m_oe, m_en, m_type, m_pol, m_stat;
    logic        m_int;
    logic [31:0] m_prdata;
    logic [15:0] hist [0:8191];
    int          cyc = 3;

    function automatic logic [15:0] events(input logic [15:0] cur, prv, typ, pol);
        logic [15:0] e;
        for (int i = 0; i < 16; i++) begin
            if (typ[i]) e[i] = pol[i] ? (cur[i] && !prv[i]) : (!cur[i] && prv[i]);
            else        e[i] = (cur[i] == pol[i]);
        end
        return e;
    endfunction

    function automatic logic [31:0] model_rd(input logic [7:0] a, input logic [15:0] din);
        if (a >= 8'h1C) return 32'h0;
        case (a[4:2])
            3'd0: return {16'h0, m_dout};
            3'd1: return {16'h0, m_oe};
            3'd2: return {16'h0, din};
            3'd3: return {16'h0, m_en};
            3'd4: return {16'h0, m_type};
            3'd5: return {16'h0, m_pol};
            3'd6: return {16'h0, m_stat};
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge pclk24) begin
        if (p_reset24) begin
            m_dout <= 16'h0; m_oe <= 16'hFFFF; m_en <= 16'h0;
            m_type <= 16'h0; m_pol <= 16'h0; m_stat <= 16'h0;
            m_int <= 1'b0; m_prdata <= 32'h0;
            hist[cyc] <= 16'h0; hist[cyc-1] <= 16'h0; hist[cyc-2] <= 16'h0;
        end else begin
            hist[cyc] <= gpio_pin_in24;
            if (psel24 && penable24 && pwrite24 && paddr24 < 8'h1C) begin
                case (paddr24[4:2])
                    3'd0: m_dout <= pwdata24[15:0];
                    3'd1: m_oe   <= pwdata24[15:0];
                    3'd3: m_en   <= pwdata24[15:0];
                    3'd4: m_type <= pwdata24[15:0];
                    3'd5: m_pol  <= pwdata24[15:0];
                    default: ;
                endcase
            end
            m_stat <= (m_stat & ~((psel24 && penable24 && pwrite24 && paddr24[7:2] == 6'd6)
                                  ? pwdata24[15:0] : 16'h0))
                    | (events(hist[cyc-2], hist[cyc-3], m_type, m_pol) & m_en);
            m_int <= |(m_stat & m_en);
            if (psel24 && !penable24 && !pwrite24) m_prdata <= model_rd(paddr24, hist[cyc-2]);
        end
        cyc <= cyc + 1;
    end

    task automatic apb_write(input logic [7:0] a, input logic [31:0] d, output logic err);
        psel24 = 1'b1; penable24 = 1'b0; pwrite24 = 1'b1; paddr24 = a; pwdata24 = d;
        @(posedge pclk24); @(negedge pclk24);
        penable24 = 1'b1;
        #1 err = pslverr24;
        @(posedge pclk24); @(negedge pclk24);
        psel24 = 1'b0; penable24 = 1'b0; pwrite24 = 1'b0;
    endtask

    task automatic apb_read(input logic [7:0] a, output logic [31:0] d, output logic err);
        psel24 = 1'b1; penable24 = 1'b0; pwrite24 = 1'b0; paddr24 = a;
        @(posedge pclk24); @(negedge pclk24);
        penable24 = 1'b1;
        #1 begin d = prdata24; err = pslverr24; end
        @(posedge pclk24); @(negedge pclk24);
        psel24 = 1'b0; penable24 = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d; logic e;
        logic [31:0] exp_rd [7];
        exp_rd = '{32'h0, 32'hFFFF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        p_reset24 = 1'b1;
        repeat (2) @(posedge pclk24);
        @(negedge pclk24);
        p_reset24 = 1'b0;
        checks++; if (gpio_int24 !== 1'b0) begin errors++; $display("FAIL reset_int got %0b exp 0", gpio_int24); end
        checks++; if (n_gpio_pin_oe24 !== 16'hFFFF) begin errors++; $display("FAIL reset_oe got %h exp ffff", n_gpio_pin_oe24); end
        checks++; if (gpio_pin_out24 !== 16'h0) begin errors++; $display("FAIL reset_out got %h exp 0", gpio_pin_out24); end
        checks++; if (prdata24 !== 32'h0) begin errors++; $display("FAIL reset_prdata got %h exp 0", prdata24); end
        for (int i = 0; i < 7; i++) begin
            apb_read(8'(i * 4), d, e);
            checks++;
            if (d !== exp_rd[i] || e !== 1'b0) begin
                errors++; $display("FAIL reset_reg%0d got %h/%0b exp %h/0", i, d, e, exp_rd[i]);
            end
        end
    endtask

    task automatic test_output();
        logic [31:0] d; logic e;
        apb_write(8'h00, 32'hA5A5, e);
        checks++; if (gpio_pin_out24 !== 16'hA5A5 || e !== 1'b0) begin errors++; $display("FAIL dout_pins got %h exp a5a5", gpio_pin_out24); end
        apb_write(8'h04, 32'h00FF, e);
        checks++; if (n_gpio_pin_oe24 !== 16'h00FF) begin errors++; $display("FAIL oe_pins got %h exp 00ff", n_gpio_pin_oe24); end
        apb_read(8'h00, d, e);
        checks++; if (d !== 32'hA5A5) begin errors++; $display("FAIL dout_rd got %h exp a5a5", d); end
        apb_read(8'h05, d, e);
        checks++; if (d !== 32'h00FF) begin errors++; $display("FAIL oe_rd got %h exp 00ff", d); end
    endtask

    task automatic test_rise();
        logic [31:0] d; logic e;
        apb_write(8'h10, 32'h1, e);
        apb_write(8'h14, 32'h1, e);
        apb_write(8'h0C, 32'h1, e);
        gpio_pin_in24[0] = 1'b1;
        @(posedge pclk24); @(negedge pclk24);
        @(posedge pclk24); @(negedge pclk24);
        checks++; if (gpio_int24 !== 1'b0) begin errors++; $display("FAIL rise_int_early got %0b exp 0", gpio_int24); end
        apb_read(8'h08, d, e);
        checks++; if (d[0] !== 1'b1) begin errors++; $display("FAIL rise_din got %h exp bit0=1", d); end
        checks++; if (gpio_int24 !== 1'b1) begin errors++; $display("FAIL rise_int got %0b exp 1", gpio_int24); end
        apb_read(8'h18, d, e);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL rise_stat got %h exp 1", d); end
        apb_write(8'h18, 32'h1, e);
        checks++; if (gpio_int24 !== 1'b1) begin errors++; $display("FAIL clr_int_lag got %0b exp 1", gpio_int24); end
        @(posedge pclk24); @(negedge pclk24);
        checks++; if (gpio_int24 !== 1'b0) begin errors++; $display("FAIL clr_int got %0b exp 0", gpio_int24); end
    endtask

    task automatic test_level();
        logic [31:0] d; logic e;
        gpio_pin_in24[3] = 1'b1;
        apb_write(8'h14, 32'h8, e);
        apb_write(8'h10, 32'h0, e);
        apb_write(8'h0C, 32'h8, e);
        repeat (3) begin @(posedge pclk24); @(negedge pclk24); end
        apb_read(8'h18, d, e);
        checks++; if (d !== 32'h8) begin errors++; $display("FAIL level_stat got %h exp 8", d); end
        apb_write(8'h18, 32'h8, e);
        checks++; if (gpio_int24 !== 1'b1) begin errors++; $display("FAIL level_int_w1c got %0b exp 1", gpio_int24); end
        apb_read(8'h18, d, e);
        checks++; if (d !== 32'h8) begin errors++; $display("FAIL level_reassert got %h exp 8", d); end
        checks++; if (gpio_int24 !== 1'b1) begin errors++; $display("FAIL level_int got %0b exp 1", gpio_int24); end
    endtask

    task automatic test_collision();
        logic [31:0] d; logic e;
        apb_write(8'h10, 32'h4, e);
        apb_write(8'h14, 32'h4, e);
        apb_write(8'h0C, 32'h4, e);
        gpio_pin_in24[2] = 1'b1;
        @(posedge pclk24); @(negedge pclk24);
        apb_write(8'h18, 32'h4, e);
        apb_read(8'h18, d, e);
        checks++; if (d !== 32'hC) begin errors++; $display("FAIL collide_stat got %h exp c", d); end
        checks++; if (gpio_int24 !== 1'b1) begin errors++; $display("FAIL collide_int got %0b exp 1", gpio_int24); end
    endtask

    task automatic test_error();
        logic [31:0] d; logic e;
        apb_read(8'h1C, d, e);
        checks++; if (d !== 32'h0 || e !== 1'b1) begin errors++; $display("FAIL err_rd got %h/%0b exp 0/1", d, e); end
        apb_write(8'h20, 32'hFFFF_FFFF, e);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL err_wr got %0b exp 1", e); end
        apb_read(8'h00, d, e);
        checks++; if (d !== 32'hA5A5 || e !== 1'b0) begin errors++; $display("FAIL err_dout got %h/%0b exp a5a5/0", d, e); end
        apb_read(8'h0C, d, e);
        checks++; if (d !== 32'h4) begin errors++; $display("FAIL err_en got %h exp 4", d); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d; logic e;
        psel24 = 1'b1; penable24 = 1'b0; pwrite24 = 1'b1; paddr24 = 8'h04; pwdata24 = 32'h1234;
        @(posedge pclk24); @(negedge pclk24);
        penable24 = 1'b1; p_reset24 = 1'b1;
        @(posedge pclk24); @(negedge pclk24);
        p_reset24 = 1'b0; psel24 = 1'b0; penable24 = 1'b0; pwrite24 = 1'b0;
        checks++; if (n_gpio_pin_oe24 !== 16'hFFFF) begin errors++; $display("FAIL mid_oe got %h exp ffff", n_gpio_pin_oe24); end
        checks++; if (gpio_pin_out24 !== 16'h0 || gpio_int24 !== 1'b0) begin errors++; $display("FAIL mid_out got %h/%0b exp 0/0", gpio_pin_out24, gpio_int24); end
        repeat (4) begin @(posedge pclk24); @(negedge pclk24); end
        apb_read(8'h18, d, e);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL mid_stat got %h exp 0", d); end
    endtask

    task automatic test_random();
        logic [31:0] d; logic e;
        int op;
        apb_write(8'h0C, 32'($urandom_range(0, 65535)), e);
        apb_write(8'h10, 32'($urandom_range(0, 65535)), e);
        apb_write(8'h14, 32'($urandom_range(0, 65535)), e);
        for (int n = 0; n < 400; n++) begin
            op = $urandom_range(0, 9);
            if (op < 6) begin
                gpio_pin_in24 = 16'($urandom);
                @(posedge pclk24); @(negedge pclk24);
            end else if (op < 8) begin
                apb_read((op == 6) ? 8'h18 : 8'h08, d, e);
                checks++; if (d !== m_prdata) begin errors++; $display("FAIL rand_rd n=%0d got %h exp %h", n, d, m_prdata); end
            end else if (op == 8) begin
                apb_write(8'h18, 32'($urandom_range(0, 65535)), e);
            end else begin
                apb_write(8'h0C + 8'($urandom_range(0, 2) * 4), 32'($urandom_range(0, 65535)), e);
            end
            checks++; if (gpio_int24 !== m_int) begin errors++; $display("FAIL rand_int n=%0d got %0b exp %0b", n, gpio_int24, m_int); end
        end
    endtask

    initial begin
        p_reset24 = 1'b1; psel24 = 1'b0; penable24 = 1'b0; pwrite24 = 1'b0;
        paddr24 = 8'h0; pwdata24 = 32'h0; gpio_pin_in24 = 16'h0;
        @(negedge pclk24);
        test_reset();
        test_output();
        test_rise();
        test_level();
        test_collision();
        test_error();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
